sim_read_sram: RTL and testbench
================================

Name: sim_read_sram

Overview:
Memory-side read responder that sits directly downstream of the arbitrated read path. It consumes the single-master read request (Read_SIGNAL / Read_ADDRESS) and returns one 64-bit word (DATA_ARRIVE / DATA_OUTSIDE) after a programmable latency. It serves as simulation/FPGA main memory for both instruction fetch and execute loads. A side write port preloads the image and services stores.

Parameters:
ADDR_W, 64, request address width
DATA_W, 64, data word width (fixed 64; 8 byte lanes)
DEPTH_WORDS, 1024, number of 64-bit words; power of two
BASE_ADDR, 64'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request sample to DATA_ARRIVE; legal range 1..15

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
Read_SIGNAL  in  1  read request level; sampled only in IDLE
Read_ADDRESS  in  ADDR_W  byte address; bits [2:0] ignored
DATA_ARRIVE  out  1  one-cycle pulse, read data valid
DATA_OUTSIDE  out  DATA_W  read data; holds last value between pulses
rd_err  out  1  pulses with DATA_ARRIVE when address out of range
wr_en  in  1  write enable (preload/store port)
wr_addr  in  ADDR_W  byte address of write; bits [2:0] ignored
wr_data  in  DATA_W  write data
wr_strb  in  8  byte-lane enables; bit i writes wr_data[8i+7:8i]

Behaviour:
- Reset (RST=1 at an edge): state<=IDLE, DATA_ARRIVE<=0, rd_err<=0, DATA_OUTSIDE<=0, latency counter<=0. Memory contents are not reset. Reset wins over every other event in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if Read_SIGNAL=1 at edge t, latch idx=(Read_ADDRESS-BASE_ADDR)>>3 and in_range=(BASE_ADDR <= addr < BASE_ADDR+8*DEPTH_WORDS). Load cnt<=LATENCY-1. Next state is WAIT if LATENCY>1, else RESP.
- WAIT: cnt decrements each cycle. When cnt==1, next state is RESP. Read_SIGNAL and Read_ADDRESS are ignored while in WAIT.
- Transition into RESP registers the response:
  - DATA_ARRIVE<=1.
  - DATA_OUTSIDE<=mem[idx] when in_range, else 64'hDEAD_BEEF_DEAD_BEEF.
  - rd_err<=!in_range.
- Latency: request sampled at edge t gives DATA_ARRIVE=1 during cycle t+LATENCY, exactly one cycle wide.
- RESP: next state is always IDLE. DATA_ARRIVE and rd_err return to 0 in the following cycle.
- Back-to-back: Read_SIGNAL still high in IDLE is a new request. Minimum request-to-request spacing is LATENCY+1 cycles, because the master holds Read_SIGNAL until it sees DATA_ARRIVE.
- Write port is independent of the FSM and commits at the edge when wr_en=1, for every strb lane set.
  - Out-of-range writes are dropped silently.
  - wr_strb=0 is a no-op.
- Same-word read/write collision at the edge entering RESP: the read is read-first and returns the pre-write data; the write still commits. Writes at any earlier edge of the WAIT window are visible to the read.
- Address arithmetic is done at ADDR_W bits. Addresses below BASE_ADDR (negative offset) are out of range and must not wrap into the array.
- Reset mid-operation (WAIT or RESP): the transaction is abandoned and no DATA_ARRIVE is produced. The master must re-issue.

Decomposition:
- Shared package sim_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - constant MEM_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
  - function addr_to_idx(addr, base)
  - function addr_in_range(addr, base, depth)
- One sub-module, sim_sram_array: DEPTH_WORDS x 64 storage with byte-strobe write and registered read-first port. The FSM/latency logic stays in sim_read_sram.

Test Plan:
- Preload mem word 0 = 64'h0000_0013_0000_0093 via wr_en/strb=8'hFF. Then Read_SIGNAL=1 at addr 0x8000_0000, LATENCY=2. Expect DATA_ARRIVE=1 exactly 2 cycles after sampling, DATA_OUTSIDE=0x0000_0013_0000_0093, rd_err=0.
- Partial write, strb=8'h0F, data 0xFFFF_FFFF_AAAA_AAAA, to a word holding 0x1111_1111_2222_2222. Then read it. Expect 0x1111_1111_AAAA_AAAA.
- Read 0x7FFF_FFF8 and read 0x8000_2000 (DEPTH=1024). Expect DATA_OUTSIDE=0xDEAD_BEEF_DEAD_BEEF with rd_err=1 on both; memory unchanged.
- Hold Read_SIGNAL high for 3 requests, LATENCY=1. Expect DATA_ARRIVE pulses spaced 2 cycles apart, each one cycle wide. Read_ADDRESS changes during WAIT are ignored.
- Same-word write on the edge entering RESP. Expect the old data returned, and a following read returns the new data.
- Assert RST during WAIT. Expect no DATA_ARRIVE, all outputs 0 next cycle, state IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/sim_mem_pkg.sv
// Shared types, constants and address helpers for the simulation main memory.
package sim_mem_pkg;

  // Read responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Pattern returned for reads that fall outside the backing array.
  localparam logic [63:0] MEM_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // Word index of a byte address relative to the array base (low 3 bits dropped).
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

  // True when base <= addr < base + 8*depth. The explicit lower-bound compare
  // keeps addresses below the base from wrapping into the array.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                         input logic [63:0] depth);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (off < (depth << 3));
  endfunction

endpackage

// File: rtl/sim_sram_array.sv
// Word-wide storage with byte-strobe writes and a registered, read-first read port.
module sim_sram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [63:0]      i_wr_data,
  input  logic [7:0]       i_wr_strb,
  output logic [63:0]      o_rd_data
);

  logic [63:0] r_mem [DEPTH_WORDS];
  logic [63:0] r_rd_data;
  logic [7:0]  w_lane_we;

  // Per-lane write enables.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign w_lane_we[gi] = i_wr_en & i_wr_strb[gi];
    end
  endgenerate

  // Byte-lane write commit; contents are deliberately never reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      if (w_lane_we[i]) begin
        r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
      end
    end
  end

  // Registered read: sampling the old contents makes a same-edge write read-first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sim_read_sram.sv
// Memory-side read responder: one 64-bit word per request after LATENCY cycles,
// plus an independent byte-strobed write port for preload and stores.
module sim_read_sram
  import sim_mem_pkg::*;
#(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 64,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Read_SIGNAL,
  input  logic [ADDR_W-1:0] Read_ADDRESS,
  output logic              DATA_ARRIVE,
  output logic [DATA_W-1:0] DATA_OUTSIDE,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [7:0]        wr_strb
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t           r_state, w_state_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_range;
  logic             r_arrive, r_err, r_data_is_err;

  logic [IDX_W-1:0] w_req_idx, w_rd_idx, w_wr_idx;
  logic             w_req_in_range, w_rd_in_range, w_wr_in_range;
  logic             w_enter_resp, w_rd_en, w_wr_en;
  logic [63:0]      w_rd_data;

  // Decode request and write addresses into array index and range flag.
  always_comb begin
    w_req_idx      = IDX_W'(addr_to_idx(64'(Read_ADDRESS), BASE_ADDR));
    w_req_in_range = addr_in_range(64'(Read_ADDRESS), BASE_ADDR, 64'(DEPTH_WORDS));
    w_wr_idx       = IDX_W'(addr_to_idx(64'(wr_addr), BASE_ADDR));
    w_wr_in_range  = addr_in_range(64'(wr_addr), BASE_ADDR, 64'(DEPTH_WORDS));
    w_wr_en        = wr_en & w_wr_in_range;
  end

  // Next-state and latency counter; flags the edge that enters RESP.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (Read_SIGNAL) begin
          w_cnt_next = LAT_M1;
          if (LATENCY > 1) begin
            w_state_next = WAIT;
          end else begin
            w_state_next = RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // With LATENCY==1 the response is taken straight from the live request.
    w_rd_idx      = (r_state == IDLE) ? w_req_idx : r_idx;
    w_rd_in_range = (r_state == IDLE) ? w_req_in_range : r_in_range;
    w_rd_en       = w_enter_resp & w_rd_in_range;
  end

  // State, counter and response flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_arrive      <= 1'b0;
      r_err         <= 1'b0;
      r_data_is_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_arrive <= w_enter_resp;
      r_err    <= w_enter_resp & ~w_rd_in_range;
      // Sticky so DATA_OUTSIDE keeps the error pattern until the next response.
      if (w_enter_resp) begin
        r_data_is_err <= ~w_rd_in_range;
      end
    end
  end

  // Latch the request address decode when a request is accepted in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx      <= '0;
      r_in_range <= 1'b0;
    end else if (r_state == IDLE && Read_SIGNAL) begin
      r_idx      <= w_req_idx;
      r_in_range <= w_req_in_range;
    end
  end

  sim_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .CLK      (CLK),
    .RST      (RST),
    .i_rd_en  (w_rd_en),
    .i_rd_idx (w_rd_idx),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_wr_idx),
    .i_wr_data(64'(wr_data)),
    .i_wr_strb(wr_strb),
    .o_rd_data(w_rd_data)
  );

  assign DATA_ARRIVE  = r_arrive;
  assign rd_err       = r_err;
  assign DATA_OUTSIDE = DATA_W'(r_data_is_err ? MEM_ERR_DATA : w_rd_data);

endmodule

// File: tb/tb_sim_read_sram.sv
// Directed bench for sim_read_sram: one instance at LATENCY=2, one at LATENCY=1,
// sharing clock, reset and the write port.
module tb_sim_read_sram;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rd2 = 1'b0, rd1 = 1'b0;
  logic [63:0] addr2 = '0, addr1 = '0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_addr = '0, wr_data = '0;
  logic [7:0]  wr_strb = '0;
  logic        arrive2, arrive1, err2, err1;
  logic [63:0] data2, data1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  sim_read_sram #(.LATENCY(2)) u_dut (
    .CLK(CLK), .RST(RST),
    .Read_SIGNAL(rd2), .Read_ADDRESS(addr2),
    .DATA_ARRIVE(arrive2), .DATA_OUTSIDE(data2), .rd_err(err2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  sim_read_sram #(.LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .Read_SIGNAL(rd1), .Read_ADDRESS(addr1),
    .DATA_ARRIVE(arrive1), .DATA_OUTSIDE(data1), .rd_err(err1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
    $display("wr   addr=%h data=%h strb=%h", a, d, s);
  endtask

  // LATENCY=2 read; the address is changed after sampling to prove it is ignored.
  task automatic do_read(input string tag, input logic [63:0] a,
                         input logic [63:0] exp_d, input logic exp_e);
    rd2 = 1'b1; addr2 = a;
    tick();
    check({tag, "_lat0"}, 64'(arrive2), 64'd0);
    addr2 = 64'h8000_0030;
    tick();
    check({tag, "_arrive"}, 64'(arrive2), 64'd1);
    check({tag, "_data"}, data2, exp_d);
    check({tag, "_err"}, 64'(err2), 64'(exp_e));
    $display("rd   addr=%h data=%h err=%0d", a, data2, err2);
    rd2 = 1'b0;
    tick();
    check({tag, "_pulse_end"}, 64'(arrive2), 64'd0);
    check({tag, "_hold"}, data2, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    check("rst_arrive", 64'(arrive2), 64'd0);
    check("rst_data", data2, 64'd0);
    check("rst_err", 64'(err2), 64'd0);
    check("rst_arrive1", 64'(arrive1), 64'd0);
    RST = 1'b0;
    tick();

    // Basic preload and read.
    do_write(64'h8000_0000, 64'h0000_0013_0000_0093, 8'hFF);
    do_read("w0", 64'h8000_0000, 64'h0000_0013_0000_0093, 1'b0);
    do_read("w0_lowbits", 64'h8000_0005, 64'h0000_0013_0000_0093, 1'b0);

    // Partial write and strobe-zero no-op.
    do_write(64'h8000_0008, 64'h1111_1111_2222_2222, 8'hFF);
    do_write(64'h8000_0008, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F);
    do_write(64'h8000_0008, 64'h9999_9999_9999_9999, 8'h00);
    do_read("partial", 64'h8000_0008, 64'h1111_1111_AAAA_AAAA, 1'b0);

    // Out-of-range writes must not wrap onto word 1023 or word 0.
    do_write(64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_write(64'h7FFF_FFF8, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
    do_write(64'h8000_2000, 64'hBAD1_BAD1_BAD1_BAD1, 8'hFF);
    do_read("oor_low", 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    do_read("oor_high", 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    do_read("last_word", 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_read("w0_intact", 64'h8000_0000, 64'h0000_0013_0000_0093, 1'b0);

    // Write on the request-sample edge is visible to the read.
    do_write(64'h8000_0018, 64'h3333_3333_3333_3333, 8'hFF);
    rd2 = 1'b1; addr2 = 64'h8000_0018;
    wr_en = 1'b1; wr_addr = 64'h8000_0018; wr_data = 64'h3C3C_3C3C_3C3C_3C3C; wr_strb = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("early_wr_lat0", 64'(arrive2), 64'd0);
    tick();
    check("early_wr_arrive", 64'(arrive2), 64'd1);
    check("early_wr_data", data2, 64'h3C3C_3C3C_3C3C_3C3C);
    $display("rd   addr=%h data=%h err=%0d (write on sample edge)", addr2, data2, err2);
    rd2 = 1'b0;
    tick();

    // Collision on the edge entering RESP: old data returned, write commits.
    do_write(64'h8000_0010, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    rd2 = 1'b1; addr2 = 64'h8000_0010;
    tick();
    wr_en = 1'b1; wr_addr = 64'h8000_0010; wr_data = 64'h5A5A_5A5A_5A5A_5A5A; wr_strb = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("collide_arrive", 64'(arrive2), 64'd1);
    check("collide_data", data2, 64'hA5A5_A5A5_A5A5_A5A5);
    $display("rd   addr=%h data=%h err=%0d (collision)", addr2, data2, err2);
    rd2 = 1'b0;
    tick();
    do_read("collide_after", 64'h8000_0010, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0);

    // Back-to-back requests at LATENCY=1 with Read_SIGNAL held high.
    do_write(64'h8000_0020, 64'h4444_4444_4444_4444, 8'hFF);
    do_write(64'h8000_0028, 64'h5555_5555_5555_5555, 8'hFF);
    do_write(64'h8000_0030, 64'h6666_6666_6666_6666, 8'hFF);
    rd1 = 1'b1; addr1 = 64'h8000_0020;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("b2b%0d_arrive", k), 64'(arrive1), 64'd1);
      check($sformatf("b2b%0d_data", k), data1, 64'h4444_4444_4444_4444 + 64'(k) * 64'h1111_1111_1111_1111);
      $display("rd1  addr=%h data=%h err=%0d", addr1, data1, err1);
      addr1 = addr1 + 64'd8;
      if (k == 2) rd1 = 1'b0;
      tick();
      check($sformatf("b2b%0d_gap", k), 64'(arrive1), 64'd0);
    end
    tick();
    check("b2b_quiet", 64'(arrive1), 64'd0);

    // Reset while in WAIT abandons the transaction.
    rd2 = 1'b1; addr2 = 64'h8000_0000;
    tick();
    RST = 1'b1; rd2 = 1'b0;
    tick();
    check("rstwait_arrive", 64'(arrive2), 64'd0);
    check("rstwait_data", data2, 64'd0);
    check("rstwait_err", 64'(err2), 64'd0);
    RST = 1'b0;
    tick();
    check("rstwait_noarrive", 64'(arrive2), 64'd0);
    $display("rst  during WAIT, arrive=%0d data=%h", arrive2, data2);
    do_read("after_rst", 64'h8000_0000, 64'h0000_0013_0000_0093, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
